// File: rtl/fdma_test_pkg.sv
// Shared types and pattern helpers for the FDMA memory tester.
package fdma_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_WREQ, ST_WDATA, ST_RREQ, ST_RDATA, ST_NEXT, ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    PAT_INC  = 2'd0,
    PAT_ADDR = 2'd1,
    PAT_WALK = 2'd2,
    PAT_LFSR = 2'd3
  } pat_e;

  // x^32 + x^22 + x^2 + x + 1, Fibonacci form shifting left: taps at bits 31, 21, 1, 0
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef struct packed {
    pat_e        mode;
    logic        sweep;
    logic [15:0] loops;
  } test_cfg_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], ^(s & LFSR_TAPS)};
  endfunction

  function automatic logic [31:0] pat_word(input pat_e mode, input logic [31:0] idx,
                                           input logic [31:0] addr, input logic [31:0] lfsr);
    logic [31:0] w;
    w = idx;
    case (mode)
      PAT_INC:  w = idx;
      PAT_ADDR: w = addr;
      PAT_WALK: w = 32'h1 << idx[4:0];
      PAT_LFSR: w = lfsr;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/fdma_pat_gen.sv
// Beat pattern generator: registered DATA_W word, reloaded per burst and advanced per beat.
module fdma_pat_gen
  import fdma_test_pkg::*;
#(
  parameter int DATA_W = 128
) (
  input  logic              ui_clk,
  input  logic              fdma_rst,
  input  logic              load,
  input  logic [31:0]       seed_addr,
  input  pat_e              mode,
  input  logic              step,
  output logic [DATA_W-1:0] data
);
  localparam int          NUM_LANES  = DATA_W / 32;
  localparam logic [31:0] BEAT_BYTES = 32'(DATA_W / 8);

  logic [31:0] idx_q, idx_d, addr_q, addr_d, lfsr_q, lfsr_d, word;
  logic [NUM_LANES-1:0][31:0] lanes;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    idx_d  = idx_q;
    addr_d = addr_q;
    lfsr_d = lfsr_q;
    if (load) begin
      idx_d  = '0;
      addr_d = seed_addr;
      lfsr_d = seed_addr | 32'h1;
    end else if (step) begin
      idx_d  = idx_q + 32'd1;
      addr_d = addr_q + BEAT_BYTES;
      lfsr_d = lfsr_step(lfsr_q);
    end
  end

  // Word is computed from the next state so the registered output already holds the upcoming beat.
  assign word = pat_word(mode, idx_d, addr_d, lfsr_d);

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign lanes[k] = word ^ 32'(k);
  end

  // Hold the output between bursts so it never toggles outside a transfer.
  always_comb begin
    data_d = data_q;
    if (load || step) data_d = lanes;
  end

  always_ff @(posedge ui_clk or posedge fdma_rst) begin
    if (fdma_rst) begin
      idx_q  <= '0;
      addr_q <= '0;
      lfsr_q <= '0;
      data_q <= '0;
    end else begin
      idx_q  <= idx_d;
      addr_q <= addr_d;
      lfsr_q <= lfsr_d;
      data_q <= data_d;
    end
  end

  assign data = data_q;

endmodule

// File: rtl/fdma_mem_tester.sv
// FDMA master that sweeps a DDR region with write/read-back bursts and counts mismatching beats.
module fdma_mem_tester
  import fdma_test_pkg::*;
#(
  parameter int          DATA_W    = 128,
  parameter int          BURST_LEN = 512,
  parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
  parameter logic [31:0] MEM_SIZE  = 32'h2000_0000,
  parameter int          ERR_CNT_W = 16
) (
  input  logic                 ui_clk,
  input  logic                 fdma_rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic [1:0]           pat_mode,
  input  logic                 sweep_mode,
  input  logic [15:0]          loops,
  output logic [31:0]          fdma_waddr,
  output logic                 fdma_wareq,
  output logic [15:0]          fdma_wsize,
  input  logic                 fdma_wbusy,
  output logic [DATA_W-1:0]    fdma_wdata,
  input  logic                 fdma_wvalid,
  output logic                 fdma_wready,
  output logic [31:0]          fdma_raddr,
  output logic                 fdma_rareq,
  output logic [15:0]          fdma_rsize,
  input  logic                 fdma_rbusy,
  input  logic [DATA_W-1:0]    fdma_rdata,
  input  logic                 fdma_rvalid,
  output logic                 fdma_rready,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [31:0]          first_err_addr,
  output logic [15:0]          pass_cnt
);
  localparam logic [31:0] BEAT_BYTES = 32'(DATA_W / 8);
  localparam logic [31:0] ADDR_INC   = 32'(BURST_LEN * DATA_W / 8);
  localparam logic [31:0] LAST_ADDR  = MEM_BASE + MEM_SIZE - ADDR_INC;

  if (DATA_W % 32 != 0) begin : g_bad_width
    $error("fdma_mem_tester: DATA_W must be a multiple of 32");
  end
  if (MEM_SIZE % ADDR_INC != 0) begin : g_bad_size
    $error("fdma_mem_tester: MEM_SIZE must be a multiple of ADDR_INC");
  end

  state_e               state_q, state_d;
  test_cfg_t            cfg_q, cfg_d;
  logic [31:0]          waddr_q, waddr_d, raddr_q, raddr_d, rbeat_addr_q, rbeat_addr_d;
  logic                 wareq_q, wareq_d, rareq_q, rareq_d;
  logic [15:0]          pass_cnt_q, pass_cnt_d, pass_next;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [31:0]          first_err_q, first_err_d;
  logic                 done_q, done_d, pass_q, pass_d, stop_q, stop_d;
  logic                 wgen_load, rgen_load, wgen_step, rgen_step, mismatch, wrap, loops_hit;
  logic [DATA_W-1:0]    rexp;

  assign busy      = !(state_q inside {ST_IDLE, ST_DONE});
  assign wgen_step = (state_q == ST_WDATA) && fdma_wvalid;
  assign rgen_step = (state_q == ST_RDATA) && fdma_rvalid;
  assign mismatch  = rgen_step && (fdma_rdata != rexp);
  assign wrap      = (raddr_q == LAST_ADDR);
  assign pass_next = pass_cnt_q + 16'd1;
  assign loops_hit = (cfg_q.loops != 16'd0) && (pass_next == cfg_q.loops);

  always_comb begin
    state_d      = state_q;
    cfg_d        = cfg_q;
    waddr_d      = waddr_q;
    raddr_d      = raddr_q;
    rbeat_addr_d = rbeat_addr_q;
    wareq_d      = 1'b0;
    rareq_d      = 1'b0;
    pass_cnt_d   = pass_cnt_q;
    err_cnt_d    = err_cnt_q;
    first_err_d  = first_err_q;
    done_d       = done_q;
    pass_d       = pass_q;
    stop_d       = stop_q | (stop & busy);
    wgen_load    = 1'b0;
    rgen_load    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          cfg_d.mode  = pat_e'(pat_mode);
          cfg_d.sweep = sweep_mode;
          cfg_d.loops = loops;
          waddr_d     = MEM_BASE;
          raddr_d     = MEM_BASE;
          pass_cnt_d  = '0;
          err_cnt_d   = '0;
          first_err_d = '0;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          stop_d      = 1'b0;
          state_d     = ST_WREQ;
        end
      end
      ST_WREQ: begin
        if (wareq_q && fdma_wbusy) begin
          wgen_load = 1'b1;
          state_d   = ST_WDATA;
        end else begin
          wareq_d = !fdma_wbusy;
        end
      end
      ST_WDATA: begin
        if (!fdma_wbusy) begin
          if (!cfg_q.sweep) begin
            raddr_d = waddr_q;
            state_d = ST_RREQ;
          end else if (waddr_q == LAST_ADDR) begin
            waddr_d = MEM_BASE;
            raddr_d = MEM_BASE;
            state_d = ST_RREQ;
          end else begin
            waddr_d = waddr_q + ADDR_INC;
            state_d = ST_WREQ;
          end
        end
      end
      ST_RREQ: begin
        if (rareq_q && fdma_rbusy) begin
          rgen_load    = 1'b1;
          rbeat_addr_d = raddr_q;
          state_d      = ST_RDATA;
        end else begin
          rareq_d = !fdma_rbusy;
        end
      end
      ST_RDATA: begin
        if (rgen_step) rbeat_addr_d = rbeat_addr_q + BEAT_BYTES;
        if (mismatch) begin
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
          if (err_cnt_q == '0) first_err_d = rbeat_addr_q;
        end
        if (!fdma_rbusy) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        raddr_d = wrap ? MEM_BASE : raddr_q + ADDR_INC;
        if (!cfg_q.sweep) waddr_d = raddr_d;
        if (wrap) pass_cnt_d = pass_next;
        // A sweep only honours stop once the whole region has been read back.
        if ((wrap && loops_hit) || (stop_q && (!cfg_q.sweep || wrap))) begin
          done_d  = 1'b1;
          pass_d  = (err_cnt_q == '0);
          state_d = ST_DONE;
        end else if (cfg_q.sweep && !wrap) begin
          state_d = ST_RREQ;
        end else begin
          state_d = ST_WREQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ui_clk or posedge fdma_rst) begin
    if (fdma_rst) begin
      state_q      <= ST_IDLE;
      cfg_q        <= '0;
      waddr_q      <= '0;
      raddr_q      <= '0;
      rbeat_addr_q <= '0;
      wareq_q      <= 1'b0;
      rareq_q      <= 1'b0;
      pass_cnt_q   <= '0;
      err_cnt_q    <= '0;
      first_err_q  <= '0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      stop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cfg_q        <= cfg_d;
      waddr_q      <= waddr_d;
      raddr_q      <= raddr_d;
      rbeat_addr_q <= rbeat_addr_d;
      wareq_q      <= wareq_d;
      rareq_q      <= rareq_d;
      pass_cnt_q   <= pass_cnt_d;
      err_cnt_q    <= err_cnt_d;
      first_err_q  <= first_err_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      stop_q       <= stop_d;
    end
  end

  fdma_pat_gen #(.DATA_W(DATA_W)) u_wgen (
    .ui_clk    (ui_clk),
    .fdma_rst  (fdma_rst),
    .load      (wgen_load),
    .seed_addr (waddr_q),
    .mode      (cfg_q.mode),
    .step      (wgen_step),
    .data      (fdma_wdata)
  );

  fdma_pat_gen #(.DATA_W(DATA_W)) u_rgen (
    .ui_clk    (ui_clk),
    .fdma_rst  (fdma_rst),
    .load      (rgen_load),
    .seed_addr (raddr_q),
    .mode      (cfg_q.mode),
    .step      (rgen_step),
    .data      (rexp)
  );

  assign fdma_waddr     = waddr_q;
  assign fdma_wareq     = wareq_q;
  assign fdma_wsize     = 16'(BURST_LEN);
  assign fdma_wready    = 1'b1;
  assign fdma_raddr     = raddr_q;
  assign fdma_rareq     = rareq_q;
  assign fdma_rsize     = 16'(BURST_LEN);
  assign fdma_rready    = 1'b1;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_addr = first_err_q;
  assign pass_cnt       = pass_cnt_q;

endmodule
